// File: rtl/race_pkg.sv
// Shared constants and small helpers for the race game datapath.
package race_pkg;

  // VGA screen geometry and pixel field widths
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // 3-bit RGB palette
  localparam logic [COLOUR_W-1:0] COL_BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] COL_GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] COL_CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] COL_RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] COL_MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] COL_YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] COL_WHITE   = 3'b111;

  // Side length of the hand-drawn car artwork
  localparam int SPRITE_DIM = 8;

  // Default start position and track limits
  localparam int X_START_DEF   = 76;
  localparam int Y_START_DEF   = 108;
  localparam int X_MIN_DEF     = 40;
  localparam int X_MAX_DEF     = 112;
  localparam int LANE_STEP_DEF = 8;
  localparam int FWD_STEP_DEF  = 2;
  localparam int FINISH_Y_DEF  = 4;

  // Resolved direction of a move strobe
  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_FWD,
    MOVE_LEFT,
    MOVE_RIGHT
  } move_e;

  // Forward wins; left and right together cancel out
  function automatic move_e decodeMove(input logic fwd, input logic lft, input logic rgt);
    if (fwd)
      return MOVE_FWD;
    else if (lft && !rgt)
      return MOVE_LEFT;
    else if (rgt && !lft)
      return MOVE_RIGHT;
    return MOVE_NONE;
  endfunction

endpackage

// File: rtl/car_sprite_rom.sv
// Combinational car artwork ROM addressed by {row, col}; col 0 is the leftmost pixel.
module car_sprite_rom
  import race_pkg::*;
#(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic [ROW_W+COL_W-1:0] i_addr,
  output logic [COLOUR_W-1:0]    o_colour
);

  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic [SPRITE_DIM*COLOUR_W-1:0] w_rowBits;

  assign w_row = i_addr[ROW_W+COL_W-1:COL_W];
  assign w_col = i_addr[COL_W-1:0];

  // Select one row of artwork (listed col 7 down to col 0), then pick the pixel
  always_comb begin
    w_rowBits = '0;
    o_colour  = COL_BLACK;
    case (int'(w_row))
      0: w_rowBits = {COL_BLACK, COL_YELLOW, COL_RED,  COL_RED,   COL_RED,   COL_RED,  COL_YELLOW, COL_BLACK};
      1: w_rowBits = {COL_BLACK, COL_RED,    COL_RED,  COL_RED,   COL_RED,   COL_RED,  COL_RED,    COL_BLACK};
      2: w_rowBits = {COL_BLACK, COL_RED,    COL_CYAN, COL_CYAN,  COL_CYAN,  COL_CYAN, COL_RED,    COL_BLACK};
      3: w_rowBits = {COL_BLACK, COL_RED,    COL_RED,  COL_RED,   COL_RED,   COL_RED,  COL_RED,    COL_BLACK};
      4: w_rowBits = {COL_BLACK, COL_RED,    COL_RED,  COL_WHITE, COL_WHITE, COL_RED,  COL_RED,    COL_BLACK};
      5: w_rowBits = {COL_BLACK, COL_RED,    COL_RED,  COL_RED,   COL_RED,   COL_RED,  COL_RED,    COL_BLACK};
      6: w_rowBits = {COL_BLACK, COL_RED,    COL_CYAN, COL_CYAN,  COL_CYAN,  COL_CYAN, COL_RED,    COL_BLACK};
      7: w_rowBits = {COL_BLACK, COL_RED,    COL_RED,  COL_RED,   COL_RED,   COL_RED,  COL_WHITE,  COL_BLACK};
      default: w_rowBits = '0;
    endcase
    if (int'(w_col) < SPRITE_DIM)
      o_colour = w_rowBits[int'(w_col)*COLOUR_W +: COLOUR_W];
  end

endmodule

// File: rtl/car_sprite_engine.sv
// Owns the car position, scans the sprite for draw/erase requests and flags the finish line.
module car_sprite_engine
  import race_pkg::*;
#(
  parameter int CAR_W     = 8,
  parameter int CAR_H     = 8,
  parameter int X_START   = X_START_DEF,
  parameter int Y_START   = Y_START_DEF,
  parameter int X_MIN     = X_MIN_DEF,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int LANE_STEP = LANE_STEP_DEF,
  parameter int FWD_STEP  = FWD_STEP_DEF,
  parameter int FINISH_Y  = FINISH_Y_DEF,
  parameter logic [COLOUR_W-1:0] ERASE_COLOUR = COL_BLACK
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                setResetSignals,
  input  logic                drawCar,
  input  logic                drawErase,
  input  logic                move,
  input  logic                forward,
  input  logic                left,
  input  logic                right,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                DoneDrawCar,
  output logic                DoneDrawErase,
  output logic                FinishedRace
);

  localparam int COL_W = $clog2(CAR_W);
  localparam int ROW_W = $clog2(CAR_H);

  localparam logic [X_W-1:0] X_START_V = X_START[X_W-1:0];
  localparam logic [Y_W-1:0] Y_START_V = Y_START[Y_W-1:0];
  localparam logic [Y_W-1:0] FINISH_V  = FINISH_Y[Y_W-1:0];
  localparam logic [X_W:0]   X_MIN_E   = X_MIN[X_W:0];
  localparam logic [X_W:0]   X_MAX_E   = X_MAX[X_W:0];
  localparam logic [X_W:0]   LANE_E    = LANE_STEP[X_W:0];
  localparam logic [Y_W:0]   FWD_E     = FWD_STEP[Y_W:0];
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CAR_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CAR_H - 1);

  logic [X_W-1:0]   r_carX;
  logic [Y_W-1:0]   r_carY;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_doneCar;
  logic             r_doneErase;

  logic             w_reqCar;
  logic             w_reqErase;
  logic             w_advance;
  logic             w_lastCol;
  logic             w_lastPix;
  move_e            w_moveDir;
  logic [X_W:0]     w_xSub;
  logic [X_W:0]     w_xAdd;
  logic [Y_W:0]     w_ySub;
  logic [X_W-1:0]   w_nextX;
  logic [Y_W-1:0]   w_nextY;
  logic [COLOUR_W-1:0] w_romColour;

  // drawCar outranks drawErase; a finished request parks until it is dropped
  assign w_reqCar   = drawCar;
  assign w_reqErase = !drawCar && drawErase;
  assign w_advance  = (w_reqCar && !r_doneCar) || (w_reqErase && !r_doneErase);
  assign w_lastCol  = (r_col == COL_LAST);
  assign w_lastPix  = w_lastCol && (r_row == ROW_LAST);

  // One bit of headroom so underflow shows up in the top bit instead of wrapping
  assign w_moveDir = decodeMove(forward, left, right);
  assign w_xSub    = {1'b0, r_carX} - LANE_E;
  assign w_xAdd    = {1'b0, r_carX} + LANE_E;
  assign w_ySub    = {1'b0, r_carY} - FWD_E;

  // Clamp the candidate position for this move direction
  always_comb begin
    w_nextX = r_carX;
    w_nextY = r_carY;
    case (w_moveDir)
      MOVE_FWD:   w_nextY = w_ySub[Y_W] ? '0 : w_ySub[Y_W-1:0];
      MOVE_LEFT:  w_nextX = (w_xSub[X_W] || (w_xSub < X_MIN_E)) ? X_MIN_E[X_W-1:0] : w_xSub[X_W-1:0];
      MOVE_RIGHT: w_nextX = (w_xAdd > X_MAX_E) ? X_MAX_E[X_W-1:0] : w_xAdd[X_W-1:0];
      default: begin
        w_nextX = r_carX;
        w_nextY = r_carY;
      end
    endcase
  end

  // Car position register, updated by move strobes
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_carX <= X_START_V;
      r_carY <= Y_START_V;
    end else if (setResetSignals) begin
      r_carX <= X_START_V;
      r_carY <= Y_START_V;
    end else if (move) begin
      r_carX <= w_nextX;
      r_carY <= w_nextY;
    end
  end

  // Row-major pixel scan; both counters wrap naturally after the last pixel
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (setResetSignals) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_advance) begin
      r_col <= r_col + COL_W'(1);
      if (w_lastCol)
        r_row <= r_row + ROW_W'(1);
    end
  end

  // Done flags set on the last pixel, sticky while the request is held
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_doneCar   <= 1'b0;
      r_doneErase <= 1'b0;
    end else if (setResetSignals) begin
      r_doneCar   <= 1'b0;
      r_doneErase <= 1'b0;
    end else begin
      r_doneCar   <= drawCar && (r_doneCar || (w_reqCar && w_lastPix));
      r_doneErase <= drawErase && (r_doneErase || (w_reqErase && w_lastPix));
    end
  end

  car_sprite_rom #(
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_rom (
    .i_addr  ({r_row, r_col}),
    .o_colour(w_romColour)
  );

  // Colour source follows the active request
  always_comb begin
    colour = '0;
    if (drawCar)
      colour = w_romColour;
    else if (drawErase)
      colour = ERASE_COLOUR;
  end

  assign x             = r_carX + X_W'(r_col);
  assign y             = r_carY + Y_W'(r_row);
  assign DoneDrawCar   = r_doneCar;
  assign DoneDrawErase = r_doneErase;
  assign FinishedRace  = (r_carY <= FINISH_V);

endmodule

// File: tb/tb_car_sprite_engine.sv
// Scoreboard bench for car_sprite_engine: stimulus queues expected pixels, a monitor compares them.
module tb_car_sprite_engine;

  logic       Clock;
  logic       Resetn;
  logic       setResetSignals;
  logic       drawCar;
  logic       drawErase;
  logic       move;
  logic       forward;
  logic       left;
  logic       right;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       DoneDrawCar;
  logic       DoneDrawErase;
  logic       FinishedRace;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Car artwork, row 0 first, col 0 leftmost: K black, R red, Y yellow, C cyan, W white
  string spriteArt[8] = '{
    "KYRRRRYK",
    "KRRRRRRK",
    "KRCCCCRK",
    "KRRRRRRK",
    "KRRWWRRK",
    "KRRRRRRK",
    "KRCCCCRK",
    "KWRRRRRK"
  };

  car_sprite_engine dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .setResetSignals(setResetSignals),
    .drawCar        (drawCar),
    .drawErase      (drawErase),
    .move           (move),
    .forward        (forward),
    .left           (left),
    .right          (right),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .DoneDrawCar    (DoneDrawCar),
    .DoneDrawErase  (DoneDrawErase),
    .FinishedRace   (FinishedRace)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [2:0] artColour(input int row, input int col);
    byte ch;
    ch = spriteArt[row].getc(col);
    case (ch)
      "R": return 3'b100;
      "Y": return 3'b110;
      "C": return 3'b011;
      "W": return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic dc, input logic de, input logic mv,
                               input logic fw, input logic lf, input logic rt, input logic sr);
    drawCar         = dc;
    drawErase       = de;
    move            = mv;
    forward         = fw;
    left            = lf;
    right           = rt;
    setResetSignals = sr;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic pushPixels(input int bx, input int by, input bit isCar, input int first, input int count);
    pix_t p;
    for (int i = first; i < first + count; i++) begin
      p.px = 8'(bx + (i % 8));
      p.py = 7'(by + (i / 8));
      p.pc = isCar ? artColour(i / 8, i % 8) : 3'b000;
      expQ.push_back(p);
    end
  endtask

  task automatic doMove(input logic fw, input logic lf, input logic rt);
    applyStimulus(0, 0, 1, fw, lf, rt, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: whenever the engine is scanning, the pixel on the bus must match the queue head
  always @(negedge Clock) begin
    if (Resetn && ((drawCar && !DoneDrawCar) || (!drawCar && drawErase && !DoneDrawErase))) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPixel", {14'd0, x, y, colour}, 32'hFFFF_FFFF);
      end else begin
        pix_t e;
        e = expQ.pop_front();
        checkOutput("pixel", {14'd0, x, y, colour}, {14'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  int expRight[5] = '{84, 92, 100, 108, 112};

  initial begin
    Resetn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    waitCycles(3);
    Resetn = 1'b1;
    waitCycles(1);

    $display("[TB] reset state");
    checkOutput("resetX", 32'(x), 76);
    checkOutput("resetY", 32'(y), 108);
    checkOutput("resetColour", 32'(colour), 0);
    checkOutput("resetDoneCar", 32'(DoneDrawCar), 0);
    checkOutput("resetDoneErase", 32'(DoneDrawErase), 0);
    checkOutput("resetFinished", 32'(FinishedRace), 0);

    $display("[TB] full draw");
    pushPixels(76, 108, 1, 0, 64);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitCycles(64);
    checkOutput("drawDoneSet", 32'(DoneDrawCar), 1);
    checkOutput("drawEraseIdle", 32'(DoneDrawErase), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    waitCycles(1);
    checkOutput("drawDoneClear", 32'(DoneDrawCar), 0);
    checkOutput("drawWrapX", 32'(x), 76);
    checkOutput("drawWrapY", 32'(y), 108);

    $display("[TB] erase");
    pushPixels(76, 108, 0, 0, 64);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    waitCycles(64);
    checkOutput("eraseDoneSet", 32'(DoneDrawErase), 1);
    checkOutput("eraseCarIdle", 32'(DoneDrawCar), 0);
    waitCycles(1);
    checkOutput("eraseDoneSticky", 32'(DoneDrawErase), 1);

    $display("[TB] async reset mid-scan");
    pushPixels(76, 108, 1, 0, 20);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    waitCycles(20);
    checkOutput("eraseStickyUnderCar", 32'(DoneDrawErase), 1);
    Resetn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("asyncX", 32'(x), 76);
    checkOutput("asyncY", 32'(y), 108);
    checkOutput("asyncDoneCar", 32'(DoneDrawCar), 0);
    checkOutput("asyncDoneErase", 32'(DoneDrawErase), 0);
    checkOutput("asyncColour", 32'(colour), 0);
    waitCycles(1);
    Resetn = 1'b1;
    waitCycles(1);

    $display("[TB] lateral clamp");
    for (int i = 0; i < 5; i++) begin
      doMove(0, 0, 1);
      checkOutput("moveRight", 32'(x), 32'(expRight[i]));
    end
    doMove(0, 1, 1);
    checkOutput("moveBothX", 32'(x), 112);
    doMove(0, 1, 0);
    checkOutput("moveLeft", 32'(x), 104);

    $display("[TB] finish line");
    for (int i = 0; i < 51; i++) doMove(1, 0, 0);
    checkOutput("fwdY51", 32'(y), 6);
    checkOutput("notFinished", 32'(FinishedRace), 0);
    doMove(1, 0, 0);
    checkOutput("fwdY52", 32'(y), 4);
    checkOutput("finished", 32'(FinishedRace), 1);
    doMove(1, 0, 0);
    doMove(1, 0, 0);
    checkOutput("fwdY0", 32'(y), 0);
    doMove(1, 0, 0);
    checkOutput("fwdSaturate", 32'(y), 0);
    doMove(1, 1, 0);
    checkOutput("fwdLeftY", 32'(y), 0);
    checkOutput("fwdLeftX", 32'(x), 104);

    $display("[TB] soft reset mid-scan");
    pushPixels(104, 0, 1, 0, 11);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitCycles(10);
    applyStimulus(1, 0, 1, 0, 0, 1, 1);
    waitCycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("softX", 32'(x), 76);
    checkOutput("softY", 32'(y), 108);
    checkOutput("softDoneCar", 32'(DoneDrawCar), 0);
    checkOutput("softFinished", 32'(FinishedRace), 0);

    $display("[TB] hold and resume");
    pushPixels(76, 108, 1, 0, 10);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitCycles(10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    waitCycles(3);
    checkOutput("holdX", 32'(x), 78);
    checkOutput("holdY", 32'(y), 109);
    checkOutput("holdColour", 32'(colour), 0);
    pushPixels(76, 108, 1, 10, 54);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    waitCycles(54);
    checkOutput("resumeDone", 32'(DoneDrawCar), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    waitCycles(1);

    checkOutput("scoreboardDrained", 32'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
